// File: rtl/cnn_kernel_mac_acc.sv
// cnn_kernel_mac_acc: KX*KY multiply-accumulate kernel that sums one window
// over CH input channels, then adds bias, applies optional ReLU and saturates.
// Pipeline: products -> product sum -> channel accumulate/final -> output.

// One window element: registered product of fmap and weight.
// Operands get one extra bit so signed and unsigned modes share a signed
// multiplier; the product width is exact for either mode.
module cnn_kernel_mac_lane #(
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic [I_F_BW-1:0]          fmap,
    input  logic [W_BW-1:0]            weight,
    output logic [I_F_BW+W_BW+1:0]     prod
);
    localparam int PW = I_F_BW + W_BW + 2;

    logic                   f_sx;
    logic                   w_sx;
    logic signed [I_F_BW:0] fx;
    logic signed [W_BW:0]   wx;

    assign f_sx = (SIGNED != 0) && fmap[I_F_BW-1];
    assign w_sx = (SIGNED != 0) && weight[W_BW-1];
    assign fx   = {f_sx, fmap};
    assign wx   = {w_sx, weight};

    // Capture the product whenever a beat is accepted; hold otherwise.
    always_ff @(posedge clk) begin
        if (clr) begin
            prod <= '0;
        end else if (en) begin
            prod <= PW'(fx * wx);
        end
    end
endmodule

module cnn_kernel_mac_acc #(
    parameter int KX      = 3,
    parameter int KY      = 3,
    parameter int I_F_BW  = 8,
    parameter int W_BW    = 8,
    parameter int CH      = 4,
    parameter int B_BW    = 16,
    parameter int O_BW    = 16,
    parameter int SIGNED  = 0,
    parameter int RELU_EN = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_soft_reset,
    input  logic                     i_in_valid,
    input  logic [KX*KY*I_F_BW-1:0]  i_in_fmap,
    input  logic [KX*KY*W_BW-1:0]    i_cnn_weight,
    input  logic [B_BW-1:0]          i_bias,
    output logic                     o_ot_valid,
    output logic [O_BW-1:0]          o_ot_result,
    output logic                     o_busy
);
    localparam int KK     = KX * KY;
    localparam int M_BW   = I_F_BW + W_BW;
    localparam int AK_BW  = M_BW + $clog2(KK);
    localparam int ACC_BW = AK_BW + $clog2(CH) + 1;
    // Internal values are carried as signed with headroom so unsigned mode
    // never wraps: product +2 bits, the sums inherit that headroom.
    localparam int PW     = M_BW + 2;
    localparam int SW     = AK_BW + 2;
    localparam int AW     = ACC_BW + 2;
    localparam int FW     = ((AW > B_BW + 1) ? AW : B_BW + 1) + 1;
    localparam int XW     = (FW > O_BW + 2) ? FW : O_BW + 2;
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
    localparam int STAGES = 3;

    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

    localparam logic signed [XW-1:0] SMAX_X = XW'($signed({1'b0, {(O_BW-1){1'b1}}}));
    localparam logic signed [XW-1:0] SMIN_X = ~SMAX_X;
    localparam logic signed [XW-1:0] UMAX_X = XW'($signed({1'b0, {O_BW{1'b1}}}));

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic                     clr;
    logic [STAGES:0]          vld_pipe;   // [0] products, [1] sum, [2] final, [3] output
    logic [1:0]               first_pipe;
    logic [1:0]               last_pipe;
    logic [CW-1:0]            ch_cnt;
    logic [0:0]               state;

    logic [KK-1:0][PW-1:0]    prod;
    logic signed [SW-1:0]     tree_sum;
    logic signed [SW-1:0]     sum_r;
    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     acc_base;
    logic signed [AW-1:0]     acc_nxt;
    logic signed [B_BW:0]     bias_e;
    logic signed [FW-1:0]     fin;
    logic signed [FW-1:0]     fin_nxt;
    logic signed [XW-1:0]     fin_x;
    logic [O_BW-1:0]          res_nxt;
    logic                     beat_first;
    logic                     beat_last;

    assign clr        = reset | i_soft_reset;
    assign beat_first = (ch_cnt == '0);
    assign beat_last  = (ch_cnt == CH_LAST);

    // Stage 1: one multiplier lane per window element.
    for (genvar k = 0; k < KK; k++) begin : g_lane
        cnn_kernel_mac_lane #(
            .I_F_BW (I_F_BW),
            .W_BW   (W_BW),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk    (clk),
            .clr    (clr),
            .en     (i_in_valid),
            .fmap   (i_in_fmap[k*I_F_BW +: I_F_BW]),
            .weight (i_cnn_weight[k*W_BW +: W_BW]),
            .prod   (prod[k])
        );
    end

    // Channel position of the incoming beat; wraps after the group's last beat.
    always_ff @(posedge clk) begin
        if (clr) begin
            ch_cnt <= '0;
        end else if (i_in_valid) begin
            ch_cnt <= beat_last ? '0 : ch_cnt + CW'(1);
        end
    end

    // Valid shift register; only last beats advance past the accumulator.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2], vld_pipe[1] & last_pipe[1], vld_pipe[0], i_in_valid};
        end
    end

    // First/last group tags travel alongside the beat data.
    always_ff @(posedge clk) begin
        if (clr) begin
            first_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            if (i_in_valid) begin
                first_pipe[0] <= beat_first;
                last_pipe[0]  <= beat_last;
            end
            if (vld_pipe[0]) begin
                first_pipe[1] <= first_pipe[0];
                last_pipe[1]  <= last_pipe[0];
            end
        end
    end

    // Stage 2 reduction over the window products, sign-extended before adding.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < KK; k++) begin
            tree_sum = tree_sum + SW'($signed(prod[k]));
        end
    end

    // Register the window sum for the accumulator stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            sum_r <= '0;
        end else if (vld_pipe[0]) begin
            sum_r <= tree_sum;
        end
    end

    // A group's first beat starts from zero, so back-to-back groups never mix.
    assign bias_e = {(SIGNED != 0) && i_bias[B_BW-1], i_bias};

    always_comb begin
        acc_base = first_pipe[1] ? '0 : acc;
        acc_nxt  = acc_base + AW'(sum_r);
        fin_nxt  = FW'(acc_base) + FW'(sum_r) + FW'(bias_e);
    end

    // Stage 3: accumulate every beat; latch the biased total on the last one.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
            fin <= '0;
        end else if (vld_pipe[1]) begin
            acc <= acc_nxt;
            if (last_pipe[1]) begin
                fin <= fin_nxt;
            end
        end
    end

    // ReLU and saturation on the exact final value.
    always_comb begin
        fin_x   = XW'(fin);
        res_nxt = fin_x[O_BW-1:0];
        if (SIGNED != 0) begin
            if ((RELU_EN != 0) && fin_x[XW-1]) begin
                res_nxt = '0;
            end else if (fin_x > SMAX_X) begin
                res_nxt = {1'b0, {(O_BW-1){1'b1}}};
            end else if (fin_x < SMIN_X) begin
                res_nxt = {1'b1, {(O_BW-1){1'b0}}};
            end
        end else if (fin_x > UMAX_X) begin
            res_nxt = '1;
        end
    end

    // Output register; result only moves together with the valid pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            o_ot_result <= '0;
        end else if (vld_pipe[2]) begin
            o_ot_result <= res_nxt;
        end
    end

    // Input-side FSM: ACCUM from the first beat until the group's last beat
    // clears stage 3 with no new group started behind it.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else if (i_in_valid) begin
            state <= ACCUM;
        end else if ((state == ACCUM) && vld_pipe[1] && last_pipe[1] && (ch_cnt == '0)) begin
            state <= IDLE;
        end
    end

    assign o_ot_valid = vld_pipe[3];
    assign o_busy     = (state == ACCUM) || (|vld_pipe);
endmodule

// File: tb/tb_cnn_kernel_mac_acc.sv
// Bench for cnn_kernel_mac_acc: three instances (unsigned, signed, signed+ReLU)
// share one stimulus stream; an arithmetic model predicts every output pixel.
module tb_cnn_kernel_mac_acc;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_soft_reset;
    logic        i_in_valid;
    logic [71:0] i_in_fmap;
    logic [71:0] i_cnn_weight;
    logic [15:0] i_bias;
    logic        v    [3];
    logic [15:0] res  [3];
    logic        busy [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses_seen = 0;
    int pulses_exp = 0;

    typedef struct {
        int          cyc;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;
    exp_t expq[$];

    // model state for the group in progress
    longint acc_u;
    longint acc_s;
    int     beat_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_kernel_mac_acc u_dut (
        .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(v[0]), .o_ot_result(res[0]), .o_busy(busy[0]));

    cnn_kernel_mac_acc #(.SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(v[1]), .o_ot_result(res[1]), .o_busy(busy[1]));

    cnn_kernel_mac_acc #(.SIGNED(1), .RELU_EN(1)) r_dut (
        .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_bias(i_bias),
        .o_ot_valid(v[2]), .o_ot_result(res[2]), .o_busy(busy[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // One channel beat; on the group's last beat, queue the predicted pixel.
    task automatic send(input logic [71:0] f, input logic [71:0] w);
        longint lu, ls, es, er;
        i_in_fmap    = f;
        i_cnn_weight = w;
        i_in_valid   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            acc_u += longint'(f[k*8 +: 8]) * longint'(w[k*8 +: 8]);
            acc_s += longint'($signed(f[k*8 +: 8])) * longint'($signed(w[k*8 +: 8]));
        end
        tick();
        i_in_valid = 1'b0;
        beat_cnt++;
        if (beat_cnt == 4) begin
            exp_t e;
            lu = acc_u + longint'(i_bias);
            ls = acc_s + longint'($signed(i_bias));
            es = (ls > 32767) ? 32767 : (ls < -32768) ? -32768 : ls;
            er = (es < 0) ? 0 : es;
            e.cyc = cyc + 3;
            e.e0  = (lu > 65535) ? 16'hFFFF : 16'(lu);
            e.e1  = 16'(es);
            e.e2  = 16'(er);
            expq.push_back(e);
            pulses_exp++;
            beat_cnt = 0;
            acc_u = 0;
            acc_s = 0;
        end
    endtask

    function automatic logic [71:0] splat(input logic [7:0] x);
        return {9{x}};
    endfunction

    // Pulse checker: timing and value of every output pixel on all instances.
    always @(negedge clk) begin
        if (v[0] === 1'b1 || v[1] === 1'b1 || v[2] === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                pulses_seen++;
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                chk("valid_u", 64'(v[0]), 64'd1);
                chk("valid_s", 64'(v[1]), 64'd1);
                chk("valid_r", 64'(v[2]), 64'd1);
                chk("result_u", 64'(res[0]), 64'(e.e0));
                chk("result_s", 64'(res[1]), 64'(e.e1));
                chk("result_r", 64'(res[2]), 64'(e.e2));
            end
        end
    end

    initial begin
        reset = 1'b1; i_soft_reset = 1'b0; i_in_valid = 1'b0;
        i_in_fmap = '0; i_cnn_weight = '0; i_bias = '0;
        acc_u = 0; acc_s = 0; beat_cnt = 0;
        tick(); tick();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", 64'(v[d]), 64'd0);
            chk("reset_result", 64'(res[d]), 64'd0);
            chk("reset_busy", 64'(busy[d]), 64'd0);
        end

        // case 1: 4*18+5 = 77
        i_bias = 16'd5;
        for (int b = 0; b < 4; b++) send(splat(8'd1), splat(8'd2));
        chk("busy_after_group", 64'(busy[0]), 64'd1);
        idle(6);
        chk("idle_busy", 64'(busy[0]), 64'd0);
        chk("hold_result_77", 64'(res[0]), 64'd77);

        // unsigned saturation; signed view is (-1)*(-1)
        i_bias = 16'd0;
        for (int b = 0; b < 4; b++) send(splat(8'hFF), splat(8'hFF));
        idle(6);

        // signed -100, ReLU clamps to 0
        i_bias = 16'd8;
        for (int b = 0; b < 4; b++) send(splat(8'hFF), splat(8'd3));
        idle(6);
        chk("signed_neg100", 64'(res[1]), 64'h0000_0000_0000_FF9C);
        chk("relu_zero", 64'(res[2]), 64'd0);

        // back-to-back groups: 72 then 144, pulses 4 cycles apart
        i_bias = 16'd0;
        for (int b = 0; b < 4; b++) send(splat(8'd1), splat(8'd2));
        for (int b = 0; b < 4; b++) send(splat(8'd2), splat(8'd2));
        idle(6);
        chk("b2b_second", 64'(res[0]), 64'd144);

        // gapped beats: busy stays high through the pulse
        i_bias = 16'd5;
        for (int b = 0; b < 4; b++) begin
            send(splat(8'd1), splat(8'd2));
            if (b < 3) begin
                for (int g = 0; g < 2; g++) begin
                    chk("gap_busy", 64'(busy[0]), 64'd1);
                    tick();
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk("tail_busy", 64'(busy[0]), 64'd1);
            tick();
        end
        idle(3);
        chk("gap_result", 64'(res[0]), 64'd77);

        // soft reset aborts a partial group
        i_bias = 16'd0;
        send(splat(8'd9), splat(8'd9));
        send(splat(8'd9), splat(8'd9));
        i_soft_reset = 1'b1;
        tick();
        i_soft_reset = 1'b0;
        beat_cnt = 0; acc_u = 0; acc_s = 0;
        for (int d = 0; d < 3; d++) chk("soft_reset_busy", 64'(busy[d]), 64'd0);
        chk("soft_reset_result", 64'(res[0]), 64'd0);
        i_bias = 16'd3;
        for (int b = 0; b < 4; b++) send(splat(8'd1), splat(8'd1));
        idle(6);

        // randomized groups with random gaps
        for (int g = 0; g < 8; g++) begin
            i_bias = 16'($urandom);
            for (int b = 0; b < 4; b++) begin
                send(72'({$urandom, $urandom, $urandom}), 72'({$urandom, $urandom, $urandom}));
                idle($urandom_range(0, 2));
            end
            idle(3);
        end

        idle(10);
        chk("pulse_count", 64'(pulses_seen), 64'(pulses_exp));
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cnn_kernel_mac_acc.md
# cnn_kernel_mac_acc

Parametrised KxK multiply-accumulate kernel for the CNN core that accumulates one window across `CH` input channels and post-processes the result. Each valid beat carries one channel's KX*KY fmap window and weights. After `CH` beats the block emits one output pixel: channel sum plus bias, optional ReLU, saturated to `O_BW`. It sits between the line-buffer/window generator and the output-channel writeback, replacing the single-channel, unsigned, fixed-3x3 kernel.

## Interface
- `KX`, 3, kernel width
- `KY`, 3, kernel height
- `I_F_BW`, 8, fmap element width
- `W_BW`, 8, weight element width
- `CH`, 4, input channels accumulated per output (>=1)
- `B_BW`, 16, bias width
- `O_BW`, 16, output width after saturation
- `SIGNED`, 0, 1 = two's-complement fmap/weight/bias/output; 0 = unsigned
- `RELU_EN`, 0, 1 = clamp negative results to 0 (no effect when SIGNED=0)
- Derived: M_BW = I_F_BW+W_BW; AK_BW = M_BW+clog2(KX*KY); ACC_BW = AK_BW+clog2(CH)+1 (+1 absorbs bias)
- `clk`  in  1  clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_soft_reset`  in  1  synchronous clear, same effect as `reset`
- `i_in_valid`  in  1  beat valid; no backpressure; every valid beat is consumed
- `i_in_fmap`  in  KX*KY*I_F_BW  window, element k at [k*I_F_BW +: I_F_BW]
- `i_cnn_weight`  in  KX*KY*W_BW  weights, element k at [k*W_BW +: W_BW]
- `i_bias`  in  B_BW  bias, sampled in stage 3 of the last beat; held stable per group
- `o_ot_valid`  out  1  one-cycle pulse, output pixel valid
- `o_ot_result`  out  O_BW  post-processed result, held until next pulse
- `o_busy`  out  1  high while a channel group is partially accepted or in flight

## Operation
- Stage 1: KX*KY parallel products, registered when `i_in_valid`; signedness per `SIGNED`.
- Stage 2: adder tree over the KX*KY registered products, sign-extended to AK_BW, registered.
- Stage 3: channel accumulator `acc` (ACC_BW). First beat of a group loads `acc <= sum`; later beats do `acc <= acc + sum`.
- Last beat in stage 3: final = acc + sum + sext/zext(i_bias); ReLU if SIGNED&&RELU_EN; saturate (unsigned: >2^O_BW-1 -> 2^O_BW-1; signed: clamp to [-2^(O_BW-1), 2^(O_BW-1)-1]); write `o_ot_result`, pulse `o_ot_valid`. The next beat is treated as a group's first.
- Channel counter `ch_cnt` (0..CH-1) advances on accepted input beats and wraps at CH-1. A first/last tag travels with each beat through the valid pipeline. CH=1 makes every beat both first and last.
- FSM on the input side: IDLE (ch_cnt=0, nothing in flight) -> ACCUM on the first valid beat; ACCUM -> IDLE when the last beat leaves stage 3 and no new beat has entered. `o_busy` = (state==ACCUM) or any pipeline valid set.
- Accumulation is exact, with no intermediate overflow for any parameter set. Saturation applies only at the output.

## Timing
- Reset (`reset` or `i_soft_reset`): all pipeline valids, ch_cnt, acc and state cleared; `o_ot_valid`=0, `o_ot_result`=0, `o_busy`=0 on the next edge. Partial groups are discarded and produce no output. `i_soft_reset` has priority over a concurrent valid beat.
- Latency: last beat sampled at edge t -> `o_ot_valid`=1 and result valid after edge t+3.
- Throughput: one beat per cycle. Back-to-back groups with no gap are supported; the last beat of group N and the first of N+1 occupy adjacent stages without interference.
- Gaps in `i_in_valid` within a group are allowed. Pipeline registers hold, and ch_cnt/acc do not advance.
- `o_ot_result` changes only on an `o_ot_valid` pulse.

## Test plan
- Defaults (unsigned, CH=4), fmap all 1, weight all 2, bias 5, 4 consecutive beats -> single pulse 3 cycles after beat 4, `o_ot_result`=77 (4*18+5).
- Unsigned O_BW=16, fmap=weight=255, bias 0, 4 beats -> raw 2,340,900 saturates to 65535.
- SIGNED=1, fmap -1, weight 3, bias 8, 4 beats -> result -100 (0xFF9C) with RELU_EN=0; result 0 with RELU_EN=1.
- Two groups back-to-back, 8 beats no gap: group A yields 72, group B (fmap 2, weight 2, bias 0) yields 144 -> pulses exactly 4 cycles apart, with no carry of A into B.
- Valid gaps: 4 beats with 2 idle cycles between each -> same 77 as case 1, pulse 3 cycles after the last beat, `o_busy` high from first beat through the pulse.
- Assert `i_soft_reset` after beat 2 of a group, then send 4 fresh beats -> no pulse from the aborted group; next pulse equals the fresh group's value; `o_busy`=0 the cycle after reset.
